mc_datapath: RTL

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle RV-style integer datapath.
// Each instruction walks IF -> ID -> EX -> (MEM) -> (WB) under a small FSM.
// Control signals come from an external decoder and are captured in ID.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   instr           : instruction word at PC, captured into IR in IF
//   ALUSrc .. Branch: control bits, captured in ID
//   immSel          : immediate format (00 I, 01 S, 10 B, 11 U)
//   ALUCtrl         : ALU operation select
//   dReadData, dAck : data memory return path
//   PC              : fetch address of the current instruction
//   dReq, dWe       : data memory request / write strobe
//   dAddress        : data memory address
//   dWriteData      : store data
//   WriteBackData   : last value presented to the register file
//   Zero            : registered ALU zero flag
//   state           : FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   instrDone       : one-cycle retire pulse
//
// Memory handshake: dReq rises on entry to MEM and stays high, with
// dAddress/dWe/dWriteData frozen, until the cycle in which dAck=1; the
// transfer completes on that edge and dReq is low the following cycle.
// dAck is ignored in every other state.
module mc_datapath #(
    parameter int          XLEN       = 32,
    parameter int          NREGS      = 32,
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            ALUSrc,
    input  logic            MemToReg,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            Branch,
    input  logic [1:0]      immSel,
    input  logic [3:0]      ALUCtrl,
    input  logic [XLEN-1:0] dReadData,
    input  logic            dAck,
    output logic [XLEN-1:0] PC,
    output logic            dReq,
    output logic            dWe,
    output logic [XLEN-1:0] dAddress,
    output logic [XLEN-1:0] dWriteData,
    output logic [XLEN-1:0] WriteBackData,
    output logic            Zero,
    output logic [2:0]      state,
    output logic            instrDone
);

    localparam int              SW     = $clog2(XLEN);
    localparam int              AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [XLEN-1:0] PC_RST = XLEN'(INITIAL_PC);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [31:0]     ir_q;
    logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
    logic            zero_q;
    logic            alusrc_q, memtoreg_q, memread_q, memwrite_q, regwrite_q, branch_q;
    logic [3:0]      aluctrl_q;
    logic [4:0]      rd_q;

    logic            dreq_q, dwe_q;
    logic [XLEN-1:0] daddr_q, dwdata_q, wbdata_q;

    logic [XLEN-1:0] regs [NREGS];

    // ---------------- immediate generation (from IR) ----------------
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_sel;

    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    // ir_q[31] doubles as the top of the 20-bit field and its sign.
    assign imm_u = {{(XLEN-31){ir_q[31]}}, ir_q[30:12], 12'b0};

    always_comb begin
        imm_sel = imm_i;
        case (immSel)
            2'b00:   imm_sel = imm_i;
            2'b01:   imm_sel = imm_s;
            2'b10:   imm_sel = imm_b;
            default: imm_sel = imm_u;
        endcase
    end

    // ---------------- register file read ----------------
    logic [4:0]      rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];

    // x0 and out-of-range indices read as zero.
    assign rs1_val = (rs1_idx == 5'd0 || 32'(rs1_idx) >= NREGS) ? '0 : regs[rs1_idx[AW-1:0]];
    assign rs2_val = (rs2_idx == 5'd0 || 32'(rs2_idx) >= NREGS) ? '0 : regs[rs2_idx[AW-1:0]];

    // ---------------- ALU ----------------
    logic [XLEN-1:0] op2, alu_res;
    logic [SW-1:0]   shamt;

    assign op2   = alusrc_q ? imm_q : b_q;
    assign shamt = op2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (aluctrl_q)
            4'b0000: alu_res = a_q & op2;
            4'b0001: alu_res = a_q | op2;
            4'b0010: alu_res = a_q + op2;
            4'b0110: alu_res = a_q - op2;
            4'b0111: alu_res = ($signed(a_q) < $signed(op2)) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
            4'b1000: alu_res = a_q >> shamt;
            4'b1001: alu_res = a_q << shamt;
            4'b1010: alu_res = $signed(a_q) >>> shamt;
            4'b1101: alu_res = a_q ^ op2;
            default: alu_res = '0;
        endcase
    end

    logic            mem_op, wb_en;
    logic [XLEN-1:0] wb_val;

    assign mem_op = memread_q | memwrite_q;
    assign wb_val = memtoreg_q ? mdr_q : alu_out_q;
    // Writes to x0 or beyond the implemented registers are dropped.
    assign wb_en  = (state_q == S_WB) && regwrite_q && (rd_q != 5'd0) && (32'(rd_q) < NREGS);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = S_IF;
        instrDone = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: state_d = S_EX;
            S_EX: begin
                if (mem_op)          state_d = S_MEM;
                else if (regwrite_q) state_d = S_WB;
                else begin
                    state_d   = S_IF;
                    instrDone = 1'b1;
                end
            end
            S_MEM: begin
                state_d = S_MEM;
                if (dAck) begin
                    if (regwrite_q) state_d = S_WB;
                    else begin
                        state_d   = S_IF;
                        instrDone = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d   = S_IF;
                instrDone = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            pc_q       <= PC_RST;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            alu_out_q  <= '0;
            mdr_q      <= '0;
            zero_q     <= 1'b0;
            alusrc_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            aluctrl_q  <= '0;
            rd_q       <= '0;
            dreq_q     <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            wbdata_q   <= '0;
        end else begin
            case (state_q)
                S_IF: ir_q <= instr;
                S_ID: begin
                    alusrc_q   <= ALUSrc;
                    memtoreg_q <= MemToReg;
                    memread_q  <= MemRead;
                    memwrite_q <= MemWrite;
                    regwrite_q <= RegWrite;
                    branch_q   <= Branch;
                    aluctrl_q  <= ALUCtrl;
                    rd_q       <= ir_q[11:7];
                    a_q        <= rs1_val;
                    b_q        <= rs2_val;
                    imm_q      <= imm_sel;
                end
                S_EX: begin
                    alu_out_q <= alu_res;
                    zero_q    <= (alu_res == '0);
                    // Branch target always uses the B-format offset from IR.
                    if (branch_q && alu_res == '0) pc_q <= pc_q + imm_b;
                    else                           pc_q <= pc_q + XLEN'(4);
                    if (mem_op) begin
                        dreq_q   <= 1'b1;
                        dwe_q    <= memwrite_q;
                        daddr_q  <= alu_res;
                        dwdata_q <= b_q;
                    end
                end
                S_MEM: begin
                    if (dAck) begin
                        dreq_q <= 1'b0;
                        dwe_q  <= 1'b0;
                        // A combined read+write is treated as a store only.
                        if (memread_q && !memwrite_q) mdr_q <= dReadData;
                    end
                end
                S_WB: wbdata_q <= wb_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[rd_q[AW-1:0]] <= wb_val;
        end
    end

    // Opcode/funct3 fields are decoded outside this block.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[6:0], ir_q[14:12]};

    assign PC            = pc_q;
    assign dReq          = dreq_q;
    assign dWe           = dwe_q;
    assign dAddress      = daddr_q;
    assign dWriteData    = dwdata_q;
    assign WriteBackData = wbdata_q;
    assign Zero          = zero_q;
    assign state         = state_q;

endmodule
